sign_extension: RTL and testbench
=================================

# sign_extension

Registered immediate-extension unit for the MIPS 32-bit single-cycle datapath. It widens the 16-bit instruction immediate to 32 bits by sign extension, zero extension, or LUI-style upper placement, selected by decoder control. Its output feeds the ALU B-operand mux and the branch-target adder. The result is registered with a valid flag so the stage can be retimed without changing the datapath contract.

## Interface
- No parameters; widths are fixed at 16-bit input and 32-bit output.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  qualifies `in`, `ExtendSign` and `Lui` for capture this cycle
- in  input  16  instruction immediate field (instr[15:0])
- ExtendSign  input  1  1 = sign-extend (replicate in[15]); 0 = zero-extend
- Lui  input  1  1 = place `in` in the upper half, {in, 16'h0000}; overrides `ExtendSign`
- out  output  32  registered extended immediate
- out_valid  output  1  registered; high for exactly the cycle after an accepted `in_valid`
- out_br  output  32  registered branch offset, {out[29:0], 2'b00} of the same captured word

## Operation
- Combinational next value `ext`, by priority:
  - Lui=1 → {in, 16'h0000}
  - else ExtendSign=1 → {{16{in[15]}}, in}
  - else → {16'h0000, in}
- Branch offset `br` = {ext[29:0], 2'b00}, i.e. ext shifted left by 2 with bits 31:30 of ext dropped.
- On a rising clk with in_valid=1: out ← ext, out_br ← br, out_valid ← 1.
- On a rising clk with in_valid=0: out and out_br hold their last values; out_valid ← 0.
- Unsigned interpretation for zero-extend: in=16'hFFE5 yields 32'h0000FFE5 and must not be treated as negative.
- No arithmetic overflow is possible; all operations are pure bit routing.
- X on a control input while in_valid=0 must not disturb state.

## Timing
- Latency: 1 cycle from an accepted input (in_valid=1 at edge N) to out/out_br/out_valid visible after edge N.
- Throughput: one input per cycle; back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No backpressure; the consumer must take out while out_valid=1.
- Reset values: out=32'h0, out_br=32'h0, out_valid=0.
  - Reset takes effect immediately on assertion, independent of clk.
  - Reset held high blocks captures even if in_valid=1.
- Reset deasserted: the first capture is at the first rising clk edge where reset=0 and in_valid=1.
- Reset asserted mid-stream: any pending result is discarded; out_valid=0 the same instant.
- All outputs are driven only from flops; no combinational path from inputs to outputs.

## Test plan
- Zero-extend negative pattern: in=16'hFFE5 (-27), ExtendSign=0, Lui=0, in_valid=1 → next cycle out=32'h0000FFE5, out_br=32'h0003FF94, out_valid=1.
- Zero-extend positive: in=16'h03E7 (+999), ExtendSign=0 → out=32'h000003E7, out_br=32'h00000F9C.
- Sign-extend negative: in=16'hFCEE (-786), ExtendSign=1 → out=32'hFFFFFCEE, out_br=32'hFFFFF3B8.
- Sign-extend positive, then a hold cycle: in=16'h002C (+44), ExtendSign=1 → out=32'h0000002C, out_br=32'h000000B0. Next cycle with in_valid=0 → out unchanged, out_valid=0.
- LUI priority: in=16'h8001, Lui=1, ExtendSign=1 → out=32'h80010000, out_br=32'h00040000.
- Async reset: assert reset between clk edges while out_valid=1 → out, out_br and out_valid read 0 before the next edge. Inputs with in_valid=1 during reset are ignored. The first valid input after release produces its result one cycle later.

Source files
------------

// File: rtl/sign_extension_if.sv
// Immediate-extension bus: decoder-side request fields and registered datapath results.
// Handshake: a word is accepted on each rising clk where in_valid=1 (no ready, no backpressure);
// out_valid is high for exactly the one cycle after an accepted word and the consumer must take it then.
interface sign_extension_if;
    logic        in_valid;
    logic [15:0] in;
    logic        ExtendSign;
    logic        Lui;
    logic [31:0] out;
    logic        out_valid;
    logic [31:0] out_br;

    modport master (
        output in_valid, in, ExtendSign, Lui,
        input  out, out_valid, out_br
    );

    modport slave (
        input  in_valid, in, ExtendSign, Lui,
        output out, out_valid, out_br
    );
endinterface

// File: rtl/sign_extension.sv
// Registered 16->32 immediate extension (sign, zero or LUI placement) plus the
// matching word-aligned branch offset, both captured together with a valid flag.
module sign_extension (
    input  logic              clk,
    input  logic              reset,
    sign_extension_if.slave   bus
);

    logic [31:0] ext;
    logic [31:0] br;

    logic [31:0] out_q,       out_d;
    logic [31:0] out_br_q,    out_br_d;
    logic        out_valid_q, out_valid_d;

    // Lui wins over ExtendSign; zero-extend keeps the immediate unsigned.
    always_comb begin
        ext = {16'h0000, bus.in};
        if (bus.Lui) begin
            ext = {bus.in, 16'h0000};
        end else if (bus.ExtendSign) begin
            ext = {{16{bus.in[15]}}, bus.in};
        end
    end

    assign br = {ext[29:0], 2'b00};

    // Controls are only looked at when in_valid is high, so idle-cycle X cannot leak into state.
    always_comb begin
        out_d       = out_q;
        out_br_d    = out_br_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            out_d       = ext;
            out_br_d    = br;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= 32'h0000_0000;
            out_br_q    <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_br_q    <= out_br_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_br    = out_br_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extension.sv
// Directed bench for sign_extension: reset, each extension mode, hold, LUI priority,
// back-to-back streaming and asynchronous reset mid-stream.
module tb_sign_extension;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  sign_extension_if bus ();

  sign_extension dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: set inputs on the falling edge, return 1 time unit after the next rising edge
  task automatic drive_cycle(input logic v, input logic [15:0] d, input logic es, input logic lui);
    @(negedge clk);
    bus.in_valid   = v;
    bus.in         = d;
    bus.ExtendSign = es;
    bus.Lui        = lui;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (bus.out !== 32'h0 || bus.out_br !== 32'h0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: out=%h out_br=%h out_valid=%b required 00000000/00000000/0",
               bus.out, bus.out_br, bus.out_valid);
    end
    // in_valid high while reset is held must be ignored
    drive_cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    drive_cycle(1'b1, 16'h5678, 1'b0, 1'b0);
    tests_run++;
    if (bus.out !== 32'h0 || bus.out_br !== 32'h0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_blocks_capture: out=%h out_br=%h out_valid=%b required 00000000/00000000/0",
               bus.out, bus.out_br, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_zero_extend();
    drive_cycle(1'b1, 16'hFFE5, 1'b0, 1'b0);
    tests_run++;
    if (bus.out !== 32'h0000FFE5 || bus.out_br !== 32'h0003FF94 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL zext_neg: out=%h out_br=%h out_valid=%b required 0000ffe5/0003ff94/1",
               bus.out, bus.out_br, bus.out_valid);
    end
    drive_cycle(1'b1, 16'h03E7, 1'b0, 1'b0);
    tests_run++;
    if (bus.out !== 32'h000003E7 || bus.out_br !== 32'h00000F9C || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL zext_pos: out=%h out_br=%h out_valid=%b required 000003e7/00000f9c/1",
               bus.out, bus.out_br, bus.out_valid);
    end
  endtask

  task automatic test_sign_extend();
    drive_cycle(1'b1, 16'hFCEE, 1'b1, 1'b0);
    tests_run++;
    if (bus.out !== 32'hFFFFFCEE || bus.out_br !== 32'hFFFFF3B8 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sext_neg: out=%h out_br=%h out_valid=%b required fffffcee/fffff3b8/1",
               bus.out, bus.out_br, bus.out_valid);
    end
    drive_cycle(1'b1, 16'h8000, 1'b1, 1'b0);
    tests_run++;
    if (bus.out !== 32'hFFFF8000 || bus.out_br !== 32'hFFFE0000) begin
      tests_failed++;
      $display("FAIL sext_min: out=%h out_br=%h required ffff8000/fffe0000", bus.out, bus.out_br);
    end
    drive_cycle(1'b1, 16'h7FFF, 1'b1, 1'b0);
    tests_run++;
    if (bus.out !== 32'h00007FFF || bus.out_br !== 32'h0001FFFC) begin
      tests_failed++;
      $display("FAIL sext_max: out=%h out_br=%h required 00007fff/0001fffc", bus.out, bus.out_br);
    end
  endtask

  task automatic test_hold();
    drive_cycle(1'b1, 16'h002C, 1'b1, 1'b0);
    tests_run++;
    if (bus.out !== 32'h0000002C || bus.out_br !== 32'h000000B0 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sext_pos: out=%h out_br=%h out_valid=%b required 0000002c/000000b0/1",
               bus.out, bus.out_br, bus.out_valid);
    end
    // idle cycles with unknown controls must leave state alone
    drive_cycle(1'b0, 16'hxxxx, 1'bx, 1'bx);
    tests_run++;
    if (bus.out !== 32'h0000002C || bus.out_br !== 32'h000000B0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_idle: out=%h out_br=%h out_valid=%b required 0000002c/000000b0/0",
               bus.out, bus.out_br, bus.out_valid);
    end
    drive_cycle(1'b0, 16'hABCD, 1'b0, 1'b1);
    tests_run++;
    if (bus.out !== 32'h0000002C || bus.out_br !== 32'h000000B0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_second: out=%h out_br=%h out_valid=%b required 0000002c/000000b0/0",
               bus.out, bus.out_br, bus.out_valid);
    end
  endtask

  task automatic test_lui();
    drive_cycle(1'b1, 16'h8001, 1'b1, 1'b1);
    tests_run++;
    if (bus.out !== 32'h80010000 || bus.out_br !== 32'h00040000 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL lui_priority: out=%h out_br=%h out_valid=%b required 80010000/00040000/1",
               bus.out, bus.out_br, bus.out_valid);
    end
    drive_cycle(1'b1, 16'h1234, 1'b0, 1'b1);
    tests_run++;
    if (bus.out !== 32'h12340000 || bus.out_br !== 32'h48D00000) begin
      tests_failed++;
      $display("FAIL lui_plain: out=%h out_br=%h required 12340000/48d00000", bus.out, bus.out_br);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vin [4];
    logic        ves [4];
    logic        vlu [4];
    logic [31:0] exp_q[$];
    logic [31:0] exp_out;
    logic [31:0] exp_br;
    vin = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'hC000};
    ves = '{1'b1,     1'b1,     1'b0,     1'b0};
    vlu = '{1'b0,     1'b0,     1'b0,     1'b1};
    // hand-computed {out, out_br} pairs
    exp_q = '{32'h00000001, 32'h00000004,
              32'hFFFFFFFF, 32'hFFFFFFFC,
              32'h0000FFFF, 32'h0003FFFC,
              32'hC0000000, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, vin[i], ves[i], vlu[i]);
      exp_out = exp_q.pop_front();
      exp_br  = exp_q.pop_front();
      tests_run++;
      if (bus.out !== exp_out || bus.out_br !== exp_br || bus.out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: out=%h out_br=%h out_valid=%b required %h/%h/1",
                 i, bus.out, bus.out_br, bus.out_valid, exp_out, exp_br);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 16'hFCEE, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.out !== 32'h0 || bus.out_br !== 32'h0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: out=%h out_br=%h out_valid=%b required 00000000/00000000/0",
               bus.out, bus.out_br, bus.out_valid);
    end
    drive_cycle(1'b1, 16'h0055, 1'b0, 1'b0);
    tests_run++;
    if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held_ignore: out=%h out_valid=%b required 00000000/0", bus.out, bus.out_valid);
    end
    // release with a valid word present: captured on the first edge after release
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in         = 16'h0102;
    bus.ExtendSign = 1'b0;
    bus.Lui        = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_no_comb: out_valid=%b required 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out !== 32'h00000102 || bus.out_br !== 32'h00000408 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_after_release: out=%h out_br=%h out_valid=%b required 00000102/00000408/1",
               bus.out, bus.out_br, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in         = 16'h0000;
    bus.ExtendSign = 1'b0;
    bus.Lui        = 1'b0;
    test_reset();
    test_zero_extend();
    test_sign_extend();
    test_hold();
    test_lui();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
